// File: rtl/mult_pkg.sv
// mult_pkg: shared types and helpers for the digit-serial multiplier.
//   state_e  - FSM states of the sequencer (IDLE, RUN, DONE)
//   digits_f - number of 2-bit digits in an operand of the given width
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int digits_f(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/mul2x2_core.sv
// mul2x2_core: combinational 2-bit x 2-bit -> 4-bit unsigned multiplier,
// written as an AND/XOR gate network (two half adders on the middle columns).
//   a, b - 2-bit unsigned operands
//   p    - 4-bit unsigned product
module mul2x2_core (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);

  logic t01, t10, t11, c1;

  assign t01  = a[0] & b[1];
  assign t10  = a[1] & b[0];
  assign t11  = a[1] & b[1];
  assign c1   = t01 & t10;      // carry out of column 1

  assign p[0] = a[0] & b[0];
  assign p[1] = t01 ^ t10;
  assign p[2] = t11 ^ c1;
  assign p[3] = t11 & c1;

endmodule

// File: rtl/digit_serial_mult.sv
// digit_serial_mult: WIDTH x WIDTH unsigned multiplier that walks every
// 2-bit digit pair of the operands through a single 2x2 core, one pair per
// clock, accumulating shifted partial products into a 2*WIDTH register.
//   clk, rst_n           - clock, async active-low reset
//   in_valid/in_ready, a, b       - operand handshake (accepted only in IDLE)
//   abort                - cancels the operation in flight, result dropped
//   out_valid/out_ready, product  - result handshake; product held until taken
// Latency from accept edge to out_valid: DIGITS*DIGITS edges.
module digit_serial_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int DIGITS = digits_f(WIDTH);
  localparam int CW     = $clog2(DIGITS);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("digit_serial_mult: WIDTH must be even and >= 4");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod_q, prod_d;
  logic [CW-1:0]      i_q, i_d, j_q, j_d;

  logic [1:0]         a_dig, b_dig;
  logic [3:0]         pp;
  logic [2*WIDTH-1:0] pp_ext, acc_sum;
  logic [CW+1:0]      sh;
  logic               last_i, last_j;

  assign a_dig = a_q[2*i_q +: 2];
  assign b_dig = b_q[2*j_q +: 2];

  mul2x2_core u_core (
    .a (a_dig),
    .b (b_dig),
    .p (pp)
  );

  // Digit weight is 4^(i+j), i.e. a left shift of 2*(i+j).
  assign sh      = {1'b0, i_q, 1'b0} + {1'b0, j_q, 1'b0};
  assign pp_ext  = {{(2*WIDTH-4){1'b0}}, pp};
  assign acc_sum = acc_q + (pp_ext << sh);
  assign last_i  = (i_q == CW'(DIGITS-1));
  assign last_j  = (j_q == CW'(DIGITS-1));

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = prod_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        // abort blocks an accept in the same cycle
        if (in_valid && !abort) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = IDLE;
        end else begin
          acc_d = acc_sum;
          if (last_j) begin
            j_d = '0;
            if (last_i) begin
              i_d     = '0;
              prod_d  = acc_sum;   // final pair folded in on the same edge
              state_d = DONE;
            end else begin
              i_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (abort) begin
          acc_d   = '0;
          state_d = IDLE;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: tb/tb_digit_serial_mult.sv
// tb_digit_serial_mult: directed bench for digit_serial_mult, one instance at
// WIDTH=8 and one at WIDTH=4. Inputs change and outputs are sampled on the
// falling edge.
module tb_digit_serial_mult;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, abort, out_valid, out_ready;
  logic [7:0]  a, b;
  logic [15:0] product;

  logic        in_valid4, in_ready4, abort4, out_valid4, out_ready4;
  logic [3:0]  a4, b4;
  logic [7:0]  product4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  digit_serial_mult #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .product(product)
  );

  digit_serial_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .abort(abort4), .out_valid(out_valid4),
    .out_ready(out_ready4), .product(product4)
  );

  // Present operands for one cycle; returns at the falling edge after the accept edge.
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
    in_valid = 1'b1; a = av; b = bv;
    @(negedge clk);
    in_valid = 1'b0; a = 8'hEE; b = 8'hDD;   // later changes must not matter
  endtask

  // Count falling edges until out_valid (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h0) begin
      fails++;
      $display("FAIL reset: in_ready=%b out_valid=%b product=%h, want 1 0 0000",
               in_ready, out_valid, product);
    end
    tests++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || product4 !== 8'h0) begin
      fails++;
      $display("FAIL reset_w4: in_ready=%b out_valid=%b product=%h, want 1 0 00",
               in_ready4, out_valid4, product4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int n;
    out_ready = 1'b1;
    start_op(8'hA5, 8'h3C);
    wait_valid(n);
    tests++;
    if (n !== 16) begin
      fails++;
      $display("FAIL basic_latency: got %0d edges, want 16", n);
    end
    tests++;
    if (product !== 16'h26AC) begin
      fails++;
      $display("FAIL basic_product: got %h, want 26ac", product);
    end
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_drain: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_patterns;
    int n;
    start_op(8'hFF, 8'hFF);
    wait_valid(n);
    tests++;
    if (n !== 16 || product !== 16'hFE01) begin
      fails++;
      $display("FAIL ff_x_ff: edges=%0d product=%h, want 16 fe01", n, product);
    end
    @(negedge clk);
    start_op(8'h00, 8'h7B);
    wait_valid(n);
    tests++;
    if (n !== 16 || product !== 16'h0000) begin
      fails++;
      $display("FAIL zero_x_7b: edges=%0d product=%h, want 16 0000", n, product);
    end
    @(negedge clk);
    tests++;
    if (product !== 16'h0000 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL idle_hold: product=%h in_ready=%b, want 0000 1", product, in_ready);
    end
  endtask

  task automatic test_backpressure;
    int n;
    int bad;
    out_ready = 1'b0;
    start_op(8'h81, 8'h7E);
    wait_valid(n);
    tests++;
    if (n !== 16 || product !== 16'h3F7E) begin
      fails++;
      $display("FAIL bp_product: edges=%0d product=%h, want 16 3f7e", n, product);
    end
    in_valid = 1'b1; a = 8'h12; b = 8'h34;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || product !== 16'h3F7E || in_ready !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bp_hold: %0d unstable cycles, want 0 (product=%h)", bad, product);
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_drain: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; a = 8'h00; b = 8'h00;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_accept: in_ready=%b, want 0", in_ready);
    end
    wait_valid(n);
    tests++;
    if (n !== 16 || product !== 16'h03A8) begin
      fails++;
      $display("FAIL bp_second: edges=%0d product=%h, want 16 03a8", n, product);
    end
    @(negedge clk);
  endtask

  task automatic test_abort;
    int n;
    int seen;
    start_op(8'hA5, 8'h3C);
    repeat (7) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_run: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL abort_no_result: out_valid seen %0d cycles, want 0", seen);
    end
    // abort beats in_valid while idle
    in_valid = 1'b1; a = 8'h77; b = 8'h77; abort = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_idle: in_ready=%b, want 1", in_ready);
    end
    start_op(8'h03, 8'h05);
    wait_valid(n);
    tests++;
    if (n !== 16 || product !== 16'h000F) begin
      fails++;
      $display("FAIL abort_next: edges=%0d product=%h, want 16 000f", n, product);
    end
    // abort in DONE wins over out_ready
    out_ready = 1'b1; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_done: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_async_reset;
    int n;
    start_op(8'h5A, 8'h11);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 16'h0) begin
      fails++;
      $display("FAIL async_reset: out_valid=%b in_ready=%b product=%h, want 0 1 0000",
               out_valid, in_ready, product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(8'h5A, 8'h11);
    wait_valid(n);
    tests++;
    if (n !== 16 || product !== 16'h05FA) begin
      fails++;
      $display("FAIL reset_fresh: edges=%0d product=%h, want 16 05fa", n, product);
    end
    @(negedge clk);
  endtask

  task automatic test_width4;
    int n;
    out_ready4 = 1'b1;
    in_valid4 = 1'b1; a4 = 4'h3; b4 = 4'h3;
    @(negedge clk);
    in_valid4 = 1'b0;
    n = 0;
    while (!out_valid4 && n < 32) begin @(negedge clk); n++; end
    tests++;
    if (n !== 4 || product4 !== 8'h09) begin
      fails++;
      $display("FAIL w4_3x3: edges=%0d product=%h, want 4 09", n, product4);
    end
    @(negedge clk);
    in_valid4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
    @(negedge clk);
    in_valid4 = 1'b0;
    n = 0;
    while (!out_valid4 && n < 32) begin @(negedge clk); n++; end
    tests++;
    if (n !== 4 || product4 !== 8'hE1) begin
      fails++;
      $display("FAIL w4_fxf: edges=%0d product=%h, want 4 e1", n, product4);
    end
    @(negedge clk);
  endtask

  initial begin
    in_valid = 1'b0; a = '0; b = '0; abort = 1'b0; out_ready = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; abort4 = 1'b0; out_ready4 = 1'b1;
    test_reset;
    test_basic;
    test_patterns;
    test_backpressure;
    test_abort;
    test_async_reset;
    test_width4;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
